// File: rtl/audio_mix_pkg.sv
// Shared defaults, accumulator sizing and FSM states for the audio mix scheduler.
package audio_mix_pkg;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_VOICE_W    = 24;
    localparam int DEF_OUT_W      = 32;
    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_UNDER_W    = 16;

    // Headroom so that summing every voice at full scale cannot wrap before the clamp.
    function automatic int acc_width(input int voice_w, input int num_voices);
        return voice_w + $clog2(num_voices);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        SAT,
        WAIT
    } mix_state_e;

endpackage

// File: rtl/mix_saturator.sv
// Clamps a wide signed mix accumulator to the voice sample range and
// left-justifies the result onto the output channel bus.
module mix_saturator #(
    parameter int ACC_W   = 26,
    parameter int VOICE_W = 24,
    parameter int OUT_W   = 32
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] sample_out
);

    localparam logic signed [ACC_W-1:0] POS_LIM = {{(ACC_W-VOICE_W+1){1'b0}}, {(VOICE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_LIM = ~POS_LIM;

    logic signed [ACC_W-1:0] acc_s;
    logic        [VOICE_W-1:0] clamped;

    assign acc_s = acc_in;

    always_comb begin
        if (acc_s > POS_LIM) begin
            clamped = POS_LIM[VOICE_W-1:0];
        end else if (acc_s < NEG_LIM) begin
            clamped = NEG_LIM[VOICE_W-1:0];
        end else begin
            clamped = acc_s[VOICE_W-1:0];
        end
        sample_out = OUT_W'(clamped) << (OUT_W - VOICE_W);
    end

endmodule

// File: rtl/audio_mix_scheduler.sv
// Frame scheduler: collects one sample per enabled voice, saturating-mixes them
// and writes the mono result into the Audio_Controller output FIFO.
module audio_mix_scheduler
    import audio_mix_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VOICE_W    = DEF_VOICE_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int UNDER_W    = DEF_UNDER_W
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_VOICES-1:0]         voice_enable,
    input  logic [NUM_VOICES-1:0]         voice_valid,
    input  logic [NUM_VOICES*VOICE_W-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]         voice_ready,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [OUT_W-1:0]              left_channel_audio_out,
    output logic [OUT_W-1:0]              right_channel_audio_out,
    output logic [UNDER_W-1:0]            underrun_count
);

    localparam int ACC_W = acc_width(VOICE_W, NUM_VOICES);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    mix_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [OUT_W-1:0]         chan_q, chan_d;
    logic [UNDER_W-1:0]       under_q, under_d;

    logic signed [VOICE_W-1:0] cur_sample;
    logic [OUT_W-1:0]          sat_out;
    logic                      advance;
    logic                      last_voice;

    mix_saturator #(
        .ACC_W   (ACC_W),
        .VOICE_W (VOICE_W),
        .OUT_W   (OUT_W)
    ) u_sat (
        .acc_in     (acc_q),
        .sample_out (sat_out)
    );

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        timer_d         = timer_q;
        chan_d          = chan_q;
        under_d         = under_q;
        voice_ready     = '0;
        write_audio_out = 1'b0;
        advance         = 1'b0;
        last_voice      = (idx_q == IDX_W'(NUM_VOICES - 1));
        cur_sample      = voice_sample[int'(idx_q)*VOICE_W +: VOICE_W];

        case (state_q)
            IDLE: begin
                state_d = COLLECT;
                idx_d   = '0;
                acc_d   = '0;
                timer_d = '0;
            end
            COLLECT: begin
                if (!voice_enable[idx_q]) begin
                    advance = 1'b1;
                end else if (voice_valid[idx_q]) begin
                    voice_ready[idx_q] = 1'b1;
                    acc_d              = acc_q + ACC_W'(cur_sample);
                    advance            = 1'b1;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    if (under_q != '1) begin
                        under_d = under_q + UNDER_W'(1);
                    end
                    advance = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end

                if (advance) begin
                    timer_d = '0;
                    if (last_voice) begin
                        state_d = SAT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            SAT: begin
                chan_d  = sat_out;
                state_d = WAIT;
            end
            WAIT: begin
                // Channel data stays frozen here until the FIFO accepts it.
                if (audio_out_allowed) begin
                    write_audio_out = 1'b1;
                    state_d         = COLLECT;
                    idx_d           = '0;
                    acc_d           = '0;
                    timer_d         = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            voice_ready     = '0;
            write_audio_out = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            timer_q <= '0;
            chan_q  <= '0;
            under_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            timer_q <= timer_d;
            chan_q  <= chan_d;
            under_q <= under_d;
        end
    end

    assign left_channel_audio_out  = chan_q;
    assign right_channel_audio_out = chan_q;
    assign underrun_count          = under_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Bench for audio_mix_scheduler: directed and random frames checked against an
// arithmetic frame model; a narrow-counter instance covers underrun saturation.
module tb_audio_mix_scheduler;

    localparam int NV     = 4;
    localparam int VW     = 24;
    localparam int OW     = 32;
    localparam int TO     = 16;
    localparam int UW     = 16;
    localparam int SAT_UW = 3;

    logic             CLOCK_50 = 1'b0;
    logic             reset;
    logic [NV-1:0]    voice_enable;
    logic [NV-1:0]    voice_valid;
    logic [NV*VW-1:0] voice_sample;
    logic [NV-1:0]    voice_ready;
    logic             audio_out_allowed;
    logic             write_audio_out;
    logic [OW-1:0]    left_channel_audio_out;
    logic [OW-1:0]    right_channel_audio_out;
    logic [UW-1:0]    underrun_count;

    logic             sat_reset;
    logic [NV-1:0]    sat_ready;
    logic             sat_write;
    logic [OW-1:0]    sat_left;
    logic [OW-1:0]    sat_right;
    logic [SAT_UW-1:0] sat_under;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_under    = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    audio_mix_scheduler #(
        .NUM_VOICES (NV), .VOICE_W (VW), .OUT_W (OW), .TIMEOUT (TO), .UNDER_W (UW)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .voice_enable            (voice_enable),
        .voice_valid             (voice_valid),
        .voice_sample            (voice_sample),
        .voice_ready             (voice_ready),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .underrun_count          (underrun_count)
    );

    // Every voice enabled but starved, so the narrow counter fills quickly.
    audio_mix_scheduler #(
        .NUM_VOICES (NV), .VOICE_W (VW), .OUT_W (OW), .TIMEOUT (TO), .UNDER_W (SAT_UW)
    ) dut_sat (
        .CLOCK_50                (CLOCK_50),
        .reset                   (sat_reset),
        .voice_enable            ({NV{1'b1}}),
        .voice_valid             ({NV{1'b0}}),
        .voice_sample            ({(NV*VW){1'b0}}),
        .voice_ready             (sat_ready),
        .audio_out_allowed       (1'b1),
        .write_audio_out         (sat_write),
        .left_channel_audio_out  (sat_left),
        .right_channel_audio_out (sat_right),
        .underrun_count          (sat_under)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [NV*VW-1:0] pack4(input int s0, input int s1, input int s2, input int s3);
        return {VW'(s3), VW'(s2), VW'(s1), VW'(s0)};
    endfunction

    // Mono mix: plain integer sum of contributing voices, clamped, then placed in the top bits.
    function automatic logic [OW-1:0] mixModel(input logic [NV-1:0] en, input logic [NV-1:0] val,
                                               input logic [NV*VW-1:0] smp);
        longint sum = 0;
        logic signed [VW-1:0] s;
        for (int i = 0; i < NV; i++) begin
            s = smp[i*VW +: VW];
            if (en[i] && val[i]) sum += longint'(s);
        end
        if (sum > 64'sd8388607)  sum = 64'sd8388607;
        if (sum < -64'sd8388608) sum = -64'sd8388608;
        return OW'(sum) << (OW - VW);
    endfunction

    // Entered just after the edge that puts the DUT in COLLECT; returns at the next COLLECT entry.
    task automatic applyStimulus(input string name, input logic [NV-1:0] en, input logic [NV-1:0] val,
                                 input logic [NV*VW-1:0] smp, input int hold);
        logic [NV-1:0] exp_ready[$];
        logic [OW-1:0] exp_mix;
        int n_under;
        int wait_cycle;
        int write_cycle;
        exp_mix = mixModel(en, val, smp);
        n_under = 0;
        for (int i = 0; i < NV; i++) begin
            if (!en[i]) begin
                exp_ready.push_back('0);
            end else if (val[i]) begin
                exp_ready.push_back(NV'(1) << i);
            end else begin
                for (int t = 0; t < TO; t++) exp_ready.push_back('0);
                n_under++;
            end
        end
        wait_cycle  = exp_ready.size() + 1;
        write_cycle = wait_cycle + hold;
        exp_under   = exp_under + n_under;
        if (exp_under > 65535) exp_under = 65535;

        voice_enable = en;
        voice_valid  = val;
        voice_sample = smp;
        for (int k = 0; k <= write_cycle; k++) begin
            audio_out_allowed = (k >= write_cycle);
            @(negedge CLOCK_50);
            checkOutput({name, " ready"}, 32'(voice_ready),
                        (k < exp_ready.size()) ? 32'(exp_ready[k]) : 32'd0);
            checkOutput({name, " write"}, 32'(write_audio_out), 32'(k == write_cycle));
            if (k >= wait_cycle) begin
                checkOutput({name, " left"},  left_channel_audio_out,  exp_mix);
                checkOutput({name, " right"}, right_channel_audio_out, exp_mix);
            end
            if (k == write_cycle) begin
                checkOutput({name, " underrun"}, 32'(underrun_count), 32'(exp_under));
            end
            @(posedge CLOCK_50);
            #1;
        end
        audio_out_allowed = 1'b0;
    endtask

    initial begin
        logic [NV-1:0]    r_en;
        logic [NV-1:0]    r_val;
        logic [NV*VW-1:0] r_smp;
        int               mode;

        reset             = 1'b1;
        sat_reset         = 1'b1;
        voice_enable      = '1;
        voice_valid       = '1;
        voice_sample      = pack4(5, 6, 7, 8);
        audio_out_allowed = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput("reset ready", 32'(voice_ready), 32'd0);
        checkOutput("reset write", 32'(write_audio_out), 32'd0);
        checkOutput("reset left",  left_channel_audio_out, 32'd0);
        checkOutput("reset right", right_channel_audio_out, 32'd0);
        checkOutput("reset underrun", 32'(underrun_count), 32'd0);

        @(posedge CLOCK_50);
        #1;
        reset             = 1'b0;
        audio_out_allowed = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("idle ready", 32'(voice_ready), 32'd0);
        checkOutput("idle write", 32'(write_audio_out), 32'd0);
        @(posedge CLOCK_50);
        #1;

        applyStimulus("basic", 4'b1111, 4'b1111, pack4(1000, 2000, -500, 16), 0);
        checkOutput("basic left const", left_channel_audio_out, 32'h0009D400);

        applyStimulus("posclip", 4'b1111, 4'b1111, pack4(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF), 0);
        checkOutput("posclip left const", left_channel_audio_out, 32'h7FFFFF00);

        applyStimulus("negclip", 4'b1111, 4'b1111, pack4(32'h800000, 32'h800000, 32'h800000, 32'h800000), 0);
        checkOutput("negclip right const", right_channel_audio_out, 32'h80000000);

        applyStimulus("starve2", 4'b1111, 4'b1011, pack4(100, 100, 100, 100), 0);
        checkOutput("starve2 left const", left_channel_audio_out, 32'h00012C00);
        checkOutput("starve2 underrun const", 32'(underrun_count), 32'd1);

        applyStimulus("backpressure", 4'b1111, 4'b1111, pack4(-7000, 12345, 99, -3), 100);

        applyStimulus("alldisabled", 4'b0000, 4'b1111, pack4(111, 222, 333, 444), 0);
        checkOutput("alldisabled left const", left_channel_audio_out, 32'd0);

        for (int f = 0; f < 20; f++) begin
            r_en = NV'($urandom);
            for (int i = 0; i < NV; i++) begin
                r_val[i] = ($urandom_range(0, 7) != 0);
                mode     = $urandom_range(0, 3);
                if (mode == 0)      r_smp[i*VW +: VW] = 24'h7FFFFF;
                else if (mode == 1) r_smp[i*VW +: VW] = 24'h800000;
                else                r_smp[i*VW +: VW] = VW'($urandom);
            end
            applyStimulus($sformatf("rand%0d", f), r_en, r_val, r_smp, $urandom_range(0, 3));
        end

        // Reset after voices 0 and 1 have been consumed.
        voice_enable = '1;
        voice_valid  = '1;
        voice_sample = pack4(40, 50, 60, 70);
        @(negedge CLOCK_50);
        checkOutput("midreset ready0", 32'(voice_ready), 32'd1);
        @(posedge CLOCK_50);
        #1;
        @(negedge CLOCK_50);
        checkOutput("midreset ready1", 32'(voice_ready), 32'd2);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("midreset cycle ready", 32'(voice_ready), 32'd0);
        checkOutput("midreset cycle write", 32'(write_audio_out), 32'd0);
        @(posedge CLOCK_50);
        #1;
        reset     = 1'b0;
        exp_under = 0;
        @(negedge CLOCK_50);
        checkOutput("postreset ready", 32'(voice_ready), 32'd0);
        checkOutput("postreset write", 32'(write_audio_out), 32'd0);
        checkOutput("postreset left",  left_channel_audio_out, 32'd0);
        checkOutput("postreset right", right_channel_audio_out, 32'd0);
        checkOutput("postreset underrun", 32'(underrun_count), 32'd0);
        @(posedge CLOCK_50);
        #1;
        applyStimulus("afterreset", 4'b1111, 4'b1111, pack4(40, 50, 60, 70), 0);

        // Starved instance: one timeout per TO cycles, counter pinned at all-ones afterwards.
        sat_reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        for (int c = 0; c <= 300; c++) begin
            @(negedge CLOCK_50);
            if (c == 48)  checkOutput("satcnt partial", 32'(sat_under), 32'd3);
            if (c == 300) checkOutput("satcnt pinned", 32'(sat_under), 32'd7);
            checkOutput("satcnt ready", 32'(sat_ready), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
